// File: rtl/id_issue_buffer.sv
// rtl/id_issue_buffer.sv - decode-to-issue instruction FIFO with branch-resolve stall (optional bypass: ID_ISSUE_BYPASS_EN)

package id_issue_buffer_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } scoreboard_entry_t;
endpackage

module id_issue_buffer
    import id_issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     flush_i,
    input  scoreboard_entry_t        decoded_instr_i,
    input  logic                     decoded_instr_valid_i,
    input  logic                     is_ctrl_flow_i,
    output logic                     decoded_instr_ack_o,
    output scoreboard_entry_t        issue_instr_o,
    output logic                     issue_instr_valid_o,
    output logic                     is_ctrl_flow_o,
    input  logic                     issue_ack_i,
    input  logic                     resolve_branch_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT_BR = 1'b1;

    scoreboard_entry_t mem_q [DEPTH];
    logic [DEPTH-1:0]  flag_q;
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     rptr_q;
    logic [PW-1:0]     wptr_q;
    logic [CW-1:0]     count_q;
    logic [0:0]        state_q;

    logic push;
    logic pop;
    logic byp_take;
    logic ctrl_pop;
    logic discard;

    assign count_o             = count_q;
    assign decoded_instr_ack_o = (count_q != CW'(DEPTH));
    assign discard             = clr_i | flush_i;

    // Head selection: storage by default, decoder forwarded when empty and idle with bypass
    always_comb begin
        issue_instr_o       = mem_q[rptr_q];
        is_ctrl_flow_o      = flag_q[rptr_q];
        issue_instr_valid_o = (count_q != '0) && (state_q == IDLE);
        byp_take            = 1'b0;
`ifdef ID_ISSUE_BYPASS_EN
        if ((count_q == '0) && (state_q == IDLE)) begin
            issue_instr_o       = decoded_instr_i;
            is_ctrl_flow_o      = is_ctrl_flow_i;
            issue_instr_valid_o = decoded_instr_valid_i;
            byp_take            = decoded_instr_valid_i & issue_ack_i;
        end
`endif
    end

    assign push     = decoded_instr_valid_i & decoded_instr_ack_o & ~byp_take;
    assign pop      = issue_instr_valid_o & issue_ack_i & ~byp_take;
    assign ctrl_pop = issue_instr_valid_o & issue_ack_i & is_ctrl_flow_o;

    // Entry payload storage; contents are don't-care until marked valid
    always_ff @(posedge clk_i) begin
        if (push && !discard) begin
            mem_q[wptr_q] <= decoded_instr_i;
        end
    end

    // Pointers, occupancy, valid/flag bits and branch-wait state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q  <= '0;
            vld_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else if (discard) begin
            vld_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            if (push) begin
                flag_q[wptr_q] <= is_ctrl_flow_i;
                vld_q[wptr_q]  <= 1'b1;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (pop) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A resolve seen in the same cycle as a branch pop belongs to an older branch
            if (state_q == IDLE) begin
                if (ctrl_pop) state_q <= WAIT_BR;
            end else if (resolve_branch_i) begin
                state_q <= IDLE;
            end
        end
    end

`ifndef SYNTHESIS
    // Handshake protocol and occupancy bookkeeping checks
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push && count_q == CW'(DEPTH)))
                else $error("id_issue_buffer: push while full");
            assert (!(issue_ack_i && !issue_instr_valid_o))
                else $error("id_issue_buffer: issue_ack_i without issue_instr_valid_o");
            assert (vld_q[rptr_q] == (count_q != '0))
                else $error("id_issue_buffer: head valid bit disagrees with count");
        end
    end
`endif

endmodule

// File: tb/tb_id_issue_buffer.sv
// tb/tb_id_issue_buffer.sv - directed self-checking bench for id_issue_buffer

module tb_id_issue_buffer;
    import id_issue_buffer_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              clr_i;
    logic              flush_i;
    scoreboard_entry_t decoded_instr_i;
    logic              decoded_instr_valid_i;
    logic              is_ctrl_flow_i;
    logic              decoded_instr_ack_o;
    scoreboard_entry_t issue_instr_o;
    logic              issue_instr_valid_o;
    logic              is_ctrl_flow_o;
    logic              issue_ack_i;
    logic              resolve_branch_i;
    logic [1:0]        count_o;
    logic              ack_req;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    // The issue stage only acknowledges an entry it is actually offered
    assign issue_ack_i = ack_req & issue_instr_valid_o;

    id_issue_buffer #(.DEPTH(2)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .clr_i                 (clr_i),
        .flush_i               (flush_i),
        .decoded_instr_i       (decoded_instr_i),
        .decoded_instr_valid_i (decoded_instr_valid_i),
        .is_ctrl_flow_i        (is_ctrl_flow_i),
        .decoded_instr_ack_o   (decoded_instr_ack_o),
        .issue_instr_o         (issue_instr_o),
        .issue_instr_valid_o   (issue_instr_valid_o),
        .is_ctrl_flow_o        (is_ctrl_flow_o),
        .issue_ack_i           (issue_ack_i),
        .resolve_branch_i      (resolve_branch_i),
        .count_o               (count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle inputs away from the edge
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic cf);
        decoded_instr_valid_i = v;
        decoded_instr_i       = '{pc: pc, op: 8'h33, rd: 5'd1, rs1: 5'd2, rs2: 5'd3};
        is_ctrl_flow_i        = cf;
        #1;
    endtask

    int unsigned exp_q[$];
    int          sent;
    int          got;
    int          cyc;

    initial begin
        rst_ni = 1'b0; clr_i = 1'b0; flush_i = 1'b0; ack_req = 1'b0;
        resolve_branch_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        tick(); tick();
        chk("reset_count", 32'(count_o), 32'd0);
        chk("reset_valid", 32'(issue_instr_valid_o), 32'd0);
        chk("reset_dack", 32'(decoded_instr_ack_o), 32'd1);
        rst_ni = 1'b1;
        tick();

        // Basic latency
        ack_req = 1'b1;
        drive(1'b1, 32'h8000_0000, 1'b0);
        chk("lat_dack", 32'(decoded_instr_ack_o), 32'd1);
`ifdef ID_ISSUE_BYPASS_EN
        chk("lat_byp_valid", 32'(issue_instr_valid_o), 32'd1);
        chk("lat_byp_pc", issue_instr_o.pc, 32'h8000_0000);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("lat_byp_count", 32'(count_o), 32'd0);
`else
        chk("lat_c1_valid", 32'(issue_instr_valid_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("lat_c2_valid", 32'(issue_instr_valid_o), 32'd1);
        chk("lat_c2_pc", issue_instr_o.pc, 32'h8000_0000);
        chk("lat_c2_count", 32'(count_o), 32'd1);
        tick();
        chk("lat_c3_count", 32'(count_o), 32'd0);
        chk("lat_c3_valid", 32'(issue_instr_valid_o), 32'd0);
`endif

        // Full
        ack_req = 1'b0;
        drive(1'b1, 32'h0, 1'b0);
        chk("full_dack0", 32'(decoded_instr_ack_o), 32'd1);
        tick();
        drive(1'b1, 32'h4, 1'b0);
        chk("full_dack1", 32'(decoded_instr_ack_o), 32'd1);
        tick();
        drive(1'b1, 32'h8, 1'b0);
        chk("full_dack2", 32'(decoded_instr_ack_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd2);
        chk("full_head", issue_instr_o.pc, 32'h0);
        tick();
        chk("full_hold_count", 32'(count_o), 32'd2);
        chk("full_hold_head", issue_instr_o.pc, 32'h0);
        ack_req = 1'b1;
        #1;
        tick();
        chk("full_drain_count", 32'(count_o), 32'd1);
        chk("full_drain_head", issue_instr_o.pc, 32'h4);
        chk("full_drain_dack", 32'(decoded_instr_ack_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("full_pushpop_count", 32'(count_o), 32'd1);
        chk("full_pushpop_head", issue_instr_o.pc, 32'h8);
        tick();
        chk("full_empty", 32'(count_o), 32'd0);

        // Branch stall
        drive(1'b1, 32'h10, 1'b1);
        tick();
        drive(1'b1, 32'h14, 1'b0);
        chk("br_head_pc", issue_instr_o.pc, 32'h10);
        chk("br_head_cf", 32'(is_ctrl_flow_o), 32'd1);
        chk("br_head_valid", 32'(issue_instr_valid_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("br_wait_valid", 32'(issue_instr_valid_o), 32'd0);
        chk("br_wait_head", issue_instr_o.pc, 32'h14);
        chk("br_wait_count", 32'(count_o), 32'd1);
        tick();
        chk("br_wait2_valid", 32'(issue_instr_valid_o), 32'd0);
        resolve_branch_i = 1'b1;
        #1;
        chk("br_resolve_cycle_valid", 32'(issue_instr_valid_o), 32'd0);
        tick();
        resolve_branch_i = 1'b0;
        #1;
        chk("br_released_valid", 32'(issue_instr_valid_o), 32'd1);
        chk("br_released_pc", issue_instr_o.pc, 32'h14);
        tick();
        chk("br_done_count", 32'(count_o), 32'd0);

        // Resolve coinciding with a branch pop
        drive(1'b1, 32'h20, 1'b1);
        tick();
        drive(1'b1, 32'h24, 1'b0);
        resolve_branch_i = 1'b1;
        #1;
        tick();
        resolve_branch_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("coin_blocked", 32'(issue_instr_valid_o), 32'd0);
        tick();
        chk("coin_still_blocked", 32'(issue_instr_valid_o), 32'd0);
        resolve_branch_i = 1'b1;
        #1;
        tick();
        resolve_branch_i = 1'b0;
        #1;
        chk("coin_released_valid", 32'(issue_instr_valid_o), 32'd1);
        chk("coin_released_pc", issue_instr_o.pc, 32'h24);
        tick();
        chk("coin_done_count", 32'(count_o), 32'd0);

        // Flush while full and waiting on a branch
        ack_req = 1'b0;
        drive(1'b1, 32'h30, 1'b1);
        tick();
        drive(1'b1, 32'h34, 1'b0);
        tick();
        drive(1'b1, 32'h38, 1'b0);
        ack_req = 1'b1;
        #1;
        tick();
        chk("fl_wait_count", 32'(count_o), 32'd1);
        chk("fl_wait_valid", 32'(issue_instr_valid_o), 32'd0);
        tick();
        chk("fl_full_count", 32'(count_o), 32'd2);
        flush_i = 1'b1;
        drive(1'b1, 32'h3c, 1'b0);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("fl_count", 32'(count_o), 32'd0);
        chk("fl_valid", 32'(issue_instr_valid_o), 32'd0);
        chk("fl_dack", 32'(decoded_instr_ack_o), 32'd1);
        drive(1'b1, 32'h40, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("fl_idle_valid", 32'(issue_instr_valid_o), 32'd1);
        chk("fl_idle_pc", issue_instr_o.pc, 32'h40);
        tick();
        chk("fl_idle_count", 32'(count_o), 32'd0);

        // Clear with a coincident push: acked but discarded
        ack_req = 1'b0;
        clr_i = 1'b1;
        drive(1'b1, 32'h50, 1'b0);
        chk("clr_dack", 32'(decoded_instr_ack_o), 32'd1);
        tick();
        clr_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("clr_count", 32'(count_o), 32'd0);
        chk("clr_valid", 32'(issue_instr_valid_o), 32'd0);

        // Wrap-around with random issue acceptance
        sent = 0; got = 0; cyc = 0;
        while (got < 10 && cyc < 200) begin
            if (sent < 10) drive(1'b1, 32'h100 + 32'(sent) * 4, 1'b0);
            else           drive(1'b0, 32'h0, 1'b0);
            ack_req = 1'($urandom_range(0, 1));
            #1;
            if (issue_ack_i) begin
                if (exp_q.size() == 0) begin
                    chk("wrap_unexpected_issue", issue_instr_o.pc, 32'hFFFF_FFFF);
                end else begin
                    chk("wrap_pc", issue_instr_o.pc, exp_q.pop_front());
                end
                got++;
            end
            if (decoded_instr_valid_i && decoded_instr_ack_o) begin
                exp_q.push_back(32'h100 + 32'(sent) * 4);
                sent++;
            end
            if (count_o > 2'd2) chk("wrap_count_bound", 32'(count_o), 32'd2);
            tick();
            cyc++;
        end
        ack_req = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("wrap_issued", 32'(got), 32'd10);
        chk("wrap_final_count", 32'(count_o), 32'd0);

        // Asynchronous reset mid-operation
        drive(1'b1, 32'h200, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("ar_pre_count", 32'(count_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("ar_count", 32'(count_o), 32'd0);
        chk("ar_valid", 32'(issue_instr_valid_o), 32'd0);
        chk("ar_dack", 32'(decoded_instr_ack_o), 32'd1);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
